ft_stream_rx: RTL and testbench

Host-end receiver for the FT byte-stream protocol used by the camera bridge. It issues the one-byte commands GET_CFG, STRT_ST and STOP_ST on an outbound byte port. It parses the 5-byte configuration reply and the per-line pixel packets arriving on an inbound byte port. Pixels are forwarded downstream with line markers, and sync, line and config errors are flagged. It sits behind the FT232H model or link in loopback benches and host-side FPGA capture designs.

---
 rtl/ft_stream_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_ft_stream_rx.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_stream_rx.sv
// Host-end FT byte-stream receiver: issues GET_CFG/STRT_ST/STOP_ST, parses the
// config reply and line packets, and forwards pixel bytes with line markers.
module ft_stream_rx #(
    parameter int IM_X       = 640,
    parameter int IM_Y       = 480,
    parameter int COLOR_MODE = 1,
    localparam int LB  = COLOR_MODE * IM_X,
    localparam int PCW = $clog2(LB + 1),
    localparam int LW  = (IM_Y > 1) ? $clog2(IM_Y) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [7:0]    cmd,
    output logic          cmd_ready,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          pix_valid,
    output logic [7:0]    pix_data,
    output logic          pix_sol,
    output logic          pix_eol,
    input  logic          pix_ready,
    output logic [LW-1:0] line_idx,
    output logic          cfg_valid,
    output logic [15:0]   cfg_im_x,
    output logic [15:0]   cfg_im_y,
    output logic          cfg_err,
    output logic          err_sync,
    output logic          err_line,
    output logic          frame_done
);
    localparam logic [7:0]     CMD_GET   = 8'h01;
    localparam logic [7:0]     CMD_STRT  = 8'h11;
    localparam logic [7:0]     CMD_STOP  = 8'h0f;
    localparam logic [7:0]     PKT_ID    = (COLOR_MODE == 2) ? 8'hBB : 8'hAA;
    localparam logic [PCW-1:0] PIX_LAST  = PCW'(LB - 1);
    localparam logic [LW-1:0]  LINE_LAST = LW'(IM_Y - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_CMD, S_CFG_RX, S_HDR_ID, S_HDR_LN, S_PIX, S_STOP_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic [2:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]     cfg_id_q, cfg_id_d;
    logic [15:0]    cfg_x_q, cfg_x_d;
    logic [7:0]     cfg_ylo_q, cfg_ylo_d;
    logic [15:0]    cfg_im_x_q, cfg_im_x_d;
    logic [15:0]    cfg_im_y_q, cfg_im_y_d;
    logic           cfg_valid_q, cfg_valid_d;
    logic           cfg_err_q, cfg_err_d;
    logic           err_sync_q, err_sync_d;
    logic           err_line_q, err_line_d;
    logic           frame_done_q, frame_done_d;
    logic [LW-1:0]  line_cnt_q, line_cnt_d;
    logic [PCW-1:0] pix_cnt_q, pix_cnt_d;

    logic       in_pix, cmd_legal, cmd_hs, rx_hs, tx_hs, pix_hs, eol_hs;
    logic [7:0] line_lo;
    logic [15:0] rx_y;

    if (LW >= 8) begin : g_lo_wide
        assign line_lo = line_cnt_q[7:0];
    end else begin : g_lo_narrow
        assign line_lo = {{(8 - LW){1'b0}}, line_cnt_q};
    end

    assign in_pix    = (state_q == S_PIX) || (state_q == S_STOP_WAIT);
    assign cmd_legal = (cmd == CMD_GET) || (cmd == CMD_STRT) || (cmd == CMD_STOP);
    assign pix_valid = in_pix && rx_valid;
    assign pix_data  = rx_data;
    assign pix_sol   = in_pix && (pix_cnt_q == '0);
    assign pix_eol   = in_pix && (pix_cnt_q == PIX_LAST);

    // In the pixel states a pending tx byte can only be the STOP command.
    always_comb begin
        cmd_ready = 1'b0;
        rx_ready  = 1'b0;
        case (state_q)
            S_IDLE:             begin cmd_ready = 1'b1; rx_ready = 1'b1; end
            S_CFG_RX, S_HDR_LN: rx_ready = 1'b1;
            S_HDR_ID:           begin rx_ready = 1'b1; cmd_ready = (cmd == CMD_STOP); end
            S_PIX:              begin rx_ready = pix_ready; cmd_ready = (cmd == CMD_STOP) && !tx_valid_q; end
            S_STOP_WAIT:        rx_ready = pix_ready;
            default:            ;
        endcase
    end

    assign cmd_hs = cmd_valid && cmd_ready;
    assign rx_hs  = rx_valid && rx_ready;
    assign tx_hs  = tx_valid_q && tx_ready;
    assign pix_hs = in_pix && rx_hs;
    assign eol_hs = pix_hs && pix_eol;
    assign rx_y   = {rx_data, cfg_ylo_q};

    always_comb begin
        state_d      = state_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        byte_cnt_d   = byte_cnt_q;
        cfg_id_d     = cfg_id_q;
        cfg_x_d      = cfg_x_q;
        cfg_ylo_d    = cfg_ylo_q;
        cfg_im_x_d   = cfg_im_x_q;
        cfg_im_y_d   = cfg_im_y_q;
        cfg_err_d    = cfg_err_q;
        line_cnt_d   = line_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        cfg_valid_d  = 1'b0;
        err_sync_d   = 1'b0;
        err_line_d   = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_hs && cmd_legal) begin
                tx_valid_d = 1'b1;
                tx_data_d  = cmd;
                state_d    = S_SEND_CMD;
            end
            S_SEND_CMD: if (tx_hs) begin
                tx_valid_d = 1'b0;
                case (tx_data_q)
                    CMD_GET:  begin state_d = S_CFG_RX; byte_cnt_d = '0; end
                    CMD_STRT: begin state_d = S_HDR_ID; line_cnt_d = '0; pix_cnt_d = '0; end
                    default:  state_d = S_IDLE;
                endcase
            end
            S_CFG_RX: if (rx_hs) begin
                byte_cnt_d = byte_cnt_q + 3'd1;
                case (byte_cnt_q)
                    3'd0:    cfg_id_d       = rx_data;
                    3'd1:    cfg_x_d[7:0]   = rx_data;
                    3'd2:    cfg_x_d[15:8]  = rx_data;
                    3'd3:    cfg_ylo_d      = rx_data;
                    default: begin
                        cfg_im_x_d  = cfg_x_q;
                        cfg_im_y_d  = rx_y;
                        cfg_valid_d = 1'b1;
                        cfg_err_d   = (cfg_id_q != PKT_ID) || (cfg_x_q != 16'(IM_X)) ||
                                      (rx_y != 16'(IM_Y));
                        state_d     = S_IDLE;
                    end
                endcase
            end
            S_HDR_ID: if (cmd_hs) begin
                tx_valid_d = 1'b1;
                tx_data_d  = CMD_STOP;
                state_d    = S_SEND_CMD;
            end else if (rx_hs) begin
                if (rx_data == PKT_ID) state_d = S_HDR_LN;
                else                   err_sync_d = 1'b1;
            end
            S_HDR_LN: if (rx_hs) begin
                err_line_d = (rx_data != line_lo);
                state_d    = S_PIX;
            end
            S_PIX, S_STOP_WAIT: begin
                if (cmd_hs) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = CMD_STOP;
                end
                if (tx_hs) tx_valid_d = 1'b0;
                if (pix_hs) pix_cnt_d = pix_eol ? '0 : pix_cnt_q + 1'b1;
                if (eol_hs) begin
                    if (line_cnt_q == LINE_LAST) begin
                        line_cnt_d   = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                    // A STOP still waiting on the link finishes in SEND_CMD.
                    if (state_q == S_STOP_WAIT || tx_hs) state_d = S_IDLE;
                    else if (tx_valid_d)                 state_d = S_SEND_CMD;
                    else                                 state_d = S_HDR_ID;
                end else if (state_q == S_PIX && tx_hs) begin
                    state_d = S_STOP_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            byte_cnt_q   <= '0;
            cfg_id_q     <= '0;
            cfg_x_q      <= '0;
            cfg_ylo_q    <= '0;
            cfg_im_x_q   <= '0;
            cfg_im_y_q   <= '0;
            cfg_valid_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
            err_sync_q   <= 1'b0;
            err_line_q   <= 1'b0;
            frame_done_q <= 1'b0;
            line_cnt_q   <= '0;
            pix_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            byte_cnt_q   <= byte_cnt_d;
            cfg_id_q     <= cfg_id_d;
            cfg_x_q      <= cfg_x_d;
            cfg_ylo_q    <= cfg_ylo_d;
            cfg_im_x_q   <= cfg_im_x_d;
            cfg_im_y_q   <= cfg_im_y_d;
            cfg_valid_q  <= cfg_valid_d;
            cfg_err_q    <= cfg_err_d;
            err_sync_q   <= err_sync_d;
            err_line_q   <= err_line_d;
            frame_done_q <= frame_done_d;
            line_cnt_q   <= line_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign line_idx   = line_cnt_q;
    assign cfg_valid  = cfg_valid_q;
    assign cfg_im_x   = cfg_im_x_q;
    assign cfg_im_y   = cfg_im_y_q;
    assign cfg_err    = cfg_err_q;
    assign err_sync   = err_sync_q;
    assign err_line   = err_line_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ft_stream_rx.sv
// Bench for ft_stream_rx: directed and randomized byte streams against a
// packet-level parser model and a pixel/pulse scoreboard.
module tb_ft_stream_rx;
    localparam int IM_X = 4;
    localparam int IM_Y = 3;
    localparam int CM   = 1;
    localparam int LB   = IM_X * CM;
    localparam int LW   = $clog2(IM_Y);
    localparam logic [7:0] PKT_ID = 8'hAA;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] d;
        logic       sol;
        logic       eol;
        int         line;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, tx_valid, tx_ready;
    logic [7:0]    cmd, tx_data, rx_data, pix_data;
    logic          rx_valid, rx_ready, pix_valid, pix_sol, pix_eol, pix_ready;
    logic [LW-1:0] line_idx;
    logic          cfg_valid, cfg_err, err_sync, err_line, frame_done;
    logic [15:0]   cfg_im_x, cfg_im_y;

    ft_stream_rx #(.IM_X(IM_X), .IM_Y(IM_Y), .COLOR_MODE(CM)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sol(pix_sol), .pix_eol(pix_eol),
        .pix_ready(pix_ready), .line_idx(line_idx), .cfg_valid(cfg_valid),
        .cfg_im_x(cfg_im_x), .cfg_im_y(cfg_im_y), .cfg_err(cfg_err),
        .err_sync(err_sync), .err_line(err_line), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    pix_t exp_q[$];
    pix_t e;
    int   m_line = 0;
    int   exp_sync = 0, exp_lerr = 0, exp_frame = 0;
    int   obs_sync = 0, obs_lerr = 0, obs_frame = 0, obs_cfg = 0, tx_cnt = 0;
    logic [15:0] obs_x, obs_y;
    logic        obs_err;
    logic [7:0]  tx_last, tx_data_prev;
    logic        tx_hold_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level parse of a byte stream that arrives while streaming.
    task automatic model_stream(input bq_t b);
        int i = 0;
        while (i < b.size()) begin
            if (b[i] != PKT_ID) begin
                exp_sync++;
                i++;
            end else begin
                int k;
                i++;
                if (i >= b.size()) break;
                if (b[i] != 8'(m_line)) exp_lerr++;
                i++;
                for (k = 0; k < LB && i < b.size(); k++) begin
                    exp_q.push_back('{d: b[i], sol: (k == 0), eol: (k == LB - 1), line: m_line});
                    i++;
                end
                if (k == LB) begin
                    m_line = (m_line + 1) % IM_Y;
                    if (m_line == 0) exp_frame++;
                end
            end
        end
    endtask

    function automatic logic cfg_err_of(input bq_t b);
        return (b[0] != PKT_ID) || ({b[2], b[1]} != 16'(IM_X)) || ({b[4], b[3]} != 16'(IM_Y));
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            tx_hold_prev = 1'b0;
        end else begin
            if (pix_valid) chk("rx_ready_mirror", 32'(rx_ready), 32'(pix_ready));
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pix", 32'(pix_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", 32'(pix_data), 32'(e.d));
                    chk("pix_sol", 32'(pix_sol), 32'(e.sol));
                    chk("pix_eol", 32'(pix_eol), 32'(e.eol));
                    chk("pix_line_idx", 32'(line_idx), e.line);
                end
            end
            if (err_sync)   obs_sync++;
            if (err_line)   obs_lerr++;
            if (frame_done) obs_frame++;
            if (cfg_valid) begin
                obs_cfg++;
                obs_x = cfg_im_x;
                obs_y = cfg_im_y;
                obs_err = cfg_err;
            end
            if (tx_hold_prev) begin
                chk("tx_hold_valid", 32'(tx_valid), 1);
                chk("tx_hold_data", 32'(tx_data), 32'(tx_data_prev));
            end
            if (tx_valid && tx_ready) begin
                tx_cnt++;
                tx_last = tx_data;
            end
            tx_hold_prev = tx_valid && !tx_ready;
            tx_data_prev = tx_data;
        end
    end

    task automatic do_cmd(input logic [7:0] c);
        int cyc = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd = c;
        @(negedge clk);
        while (!cmd_ready) begin
            cyc++;
            if (cyc > 50) begin
                chk("cmd_timeout", 32'(cmd_ready), 1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        int cyc = 0;
        while (tx_cnt < target) begin
            @(negedge clk);
            cyc++;
            if (cyc > 100) begin
                chk("tx_timeout", tx_cnt, target);
                break;
            end
        end
    endtask

    // rdy_pct < 0 toggles pix_ready every cycle.
    task automatic drive_rx(input bq_t b, input int rx_pct, input int rdy_pct);
        int idx = 0;
        int cyc = 0;
        while (idx < b.size()) begin
            @(posedge clk); #1;
            rx_valid = ($urandom_range(99) < rx_pct);
            rx_data = b[idx];
            if (rdy_pct < 0) pix_ready = !pix_ready;
            else             pix_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (rx_valid && rx_ready) idx++;
            cyc++;
            if (cyc > 40 * b.size() + 100) begin
                chk("rx_timeout", idx, b.size());
                break;
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        pix_ready = 1'b1;
    endtask

    task automatic settle_and_count();
        repeat (3) @(negedge clk);
        chk("sync_cnt", obs_sync, exp_sync);
        chk("line_err_cnt", obs_lerr, exp_lerr);
        chk("frame_cnt", obs_frame, exp_frame);
        chk("pix_left", exp_q.size(), 0);
        chk("line_idx", 32'(line_idx), m_line);
    endtask

    task automatic cfg_test(input bq_t b, input int hold, input logic [15:0] lx,
                            input logic [15:0] ly, input logic le);
        int n0 = obs_cfg;
        int t0 = tx_cnt;
        tx_ready = (hold == 0);
        do_cmd(8'h01);
        @(negedge clk);
        chk("cmd_to_tx_valid", 32'(tx_valid), 1);
        chk("cmd_to_tx_data", 32'(tx_data), 32'h01);
        repeat (hold) @(negedge clk);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_tx(t0 + 1);
        chk("tx_once", tx_cnt, t0 + 1);
        chk("tx_get_cfg", 32'(tx_last), 32'h01);
        drive_rx(b, 100, 100);
        @(negedge clk);
        chk("cfg_valid_pulse", 32'(cfg_valid), 1);
        @(negedge clk);
        chk("cfg_valid_drop", 32'(cfg_valid), 0);
        chk("cfg_cnt", obs_cfg, n0 + 1);
        chk("cfg_x_model", 32'(obs_x), 32'({b[2], b[1]}));
        chk("cfg_y_model", 32'(obs_y), 32'({b[4], b[3]}));
        chk("cfg_err_model", 32'(obs_err), 32'(cfg_err_of(b)));
        chk("cfg_x_lit", 32'(obs_x), 32'(lx));
        chk("cfg_y_lit", 32'(obs_y), 32'(ly));
        chk("cfg_err_lit", 32'(obs_err), 32'(le));
    endtask

    initial begin
        bq_t b, b2;
        int  t0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd = 8'h01; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; pix_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_cfg_valid", 32'(cfg_valid), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_pulses", 32'({err_sync, err_line, frame_done}), 0);
        chk("rst_cfg_x", 32'(cfg_im_x), 0);
        chk("rst_cfg_y", 32'(cfg_im_y), 0);
        chk("rst_line_idx", 32'(line_idx), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rx_ready", 32'(rx_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        cfg_test('{8'hAA, 8'h04, 8'h00, 8'h03, 8'h00}, 3, 16'd4, 16'd3, 1'b0);
        cfg_test('{8'hAA, 8'h80, 8'h02, 8'hE0, 8'h01}, 0, 16'd640, 16'd480, 1'b1);
        cfg_test('{8'hBB, 8'h04, 8'h00, 8'h03, 8'h00}, 0, 16'd4, 16'd3, 1'b1);

        t0 = tx_cnt;
        do_cmd(8'h22);
        repeat (3) @(negedge clk);
        chk("illegal_no_tx", tx_cnt, t0);
        chk("illegal_tx_valid", 32'(tx_valid), 0);

        // Directed stream with resync, line error and toggling backpressure.
        tx_ready = 1'b1;
        do_cmd(8'h11);
        wait_tx(t0 + 1);
        chk("tx_strt", 32'(tx_last), 32'h11);
        m_line = 0;
        b = '{8'h55, 8'hAA, 8'h05, 8'h10, 8'h11, 8'h12, 8'h13,
              8'hAA, 8'h01, 8'h20, 8'h21, 8'h22, 8'h23,
              8'hAA, 8'h02, 8'h30, 8'h31, 8'h32, 8'h33};
        model_stream(b);
        drive_rx(b, 100, -1);
        settle_and_count();
        chk("lit_sync", obs_sync, 1);
        chk("lit_line_err", obs_lerr, 1);
        chk("lit_frame", obs_frame, 1);
        chk("lit_line_idx", 32'(line_idx), 0);

        for (int it = 0; it < 8; it++) begin
            int gl = m_line;
            int nl = $urandom_range(1, 5);
            b = {};
            for (int l = 0; l < nl; l++) begin
                int nj = ($urandom_range(99) < 30) ? $urandom_range(1, 2) : 0;
                for (int j = 0; j < nj; j++) begin
                    logic [7:0] jb = 8'($urandom_range(255));
                    if (jb == PKT_ID) jb = 8'h55;
                    b.push_back(jb);
                end
                b.push_back(PKT_ID);
                b.push_back(($urandom_range(99) < 80) ? 8'(gl) : 8'($urandom_range(255)));
                for (int k = 0; k < LB; k++) b.push_back(8'($urandom_range(255)));
                gl = (gl + 1) % IM_Y;
            end
            model_stream(b);
            drive_rx(b, $urandom_range(40, 100), $urandom_range(30, 100));
            settle_and_count();
        end

        // STOP issued mid-line: rest of the line still forwarded, then idle.
        b  = '{PKT_ID, 8'(m_line), 8'h40, 8'h41};
        b2 = '{8'h42, 8'h43};
        model_stream({b, b2});
        drive_rx(b, 100, 100);
        @(posedge clk); #1;
        cmd = 8'h01;
        @(negedge clk);
        chk("pix_cmd_ready_non_stop", 32'(cmd_ready), 0);
        t0 = tx_cnt;
        do_cmd(8'h0f);
        wait_tx(t0 + 1);
        chk("tx_stop", 32'(tx_last), 32'h0f);
        drive_rx(b2, 100, 100);
        cmd = 8'h01;
        settle_and_count();
        chk("stop_idle_cmd_ready", 32'(cmd_ready), 1);
        drive_rx('{8'h77}, 100, 100);
        settle_and_count();

        // STOP accepted on the eol byte while the link stalls.
        t0 = tx_cnt;
        do_cmd(8'h11);
        wait_tx(t0 + 1);
        m_line = 0;
        b = '{PKT_ID, 8'h00, 8'h50, 8'h51, 8'h52};
        model_stream({b, 8'h53});
        drive_rx(b, 100, 100);
        tx_ready = 1'b0;
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h53; pix_ready = 1'b1;
        cmd_valid = 1'b1; cmd = 8'h0f;
        @(negedge clk);
        chk("stop_eol_cmd_ready", 32'(cmd_ready), 1);
        chk("stop_eol_rx_ready", 32'(rx_ready), 1);
        @(posedge clk); #1;
        rx_valid = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("stop_eol_tx_valid", 32'(tx_valid), 1);
        chk("stop_eol_tx_data", 32'(tx_data), 32'h0f);
        chk("stop_eol_wait_cmd_ready", 32'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_tx(t0 + 2);
        cmd = 8'h01;
        settle_and_count();
        chk("stop_eol_idle", 32'(cmd_ready), 1);
        chk("lit_stop_eol_line", 32'(line_idx), 1);
        drive_rx('{8'h66}, 100, 100);
        settle_and_count();

        // Reset in the middle of a line packet.
        t0 = tx_cnt;
        do_cmd(8'h11);
        wait_tx(t0 + 1);
        m_line = 0;
        b = '{PKT_ID, 8'h00, 8'h60, 8'h61};
        model_stream(b);
        drive_rx(b, 100, 100);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h62;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pix_valid", 32'(pix_valid), 0);
        chk("mid_rst_line_idx", 32'(line_idx), 0);
        chk("mid_rst_cfg_x", 32'(cfg_im_x), 0);
        chk("mid_rst_cfg_err", 32'(cfg_err), 0);
        chk("mid_rst_tx_valid", 32'(tx_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0; rx_valid = 1'b0;
        m_line = 0;
        settle_and_count();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
